dt_res_packer: RTL and testbench
================================

# dt_res_packer

Reads the 128×128 8-bit distance map from the result RAM (14-bit address, one byte per pixel) and writes a thresholded binary image to a 1024-word × 16-bit bitmap RAM. The packing is the same one the distance-transform front end unpacks: 16 pixels per word, first pixel in bit 15. The block sits after the distance-transform engine. It regenerates foreground masks (distance ≥ thr) in the input-image format for downstream reuse and for bench comparison.

## Interface
Parameters:
- THR_W, 8, width of threshold and pixel data.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; accepted only in IDLE or DONE.
- thr  in  8  threshold; sampled in the cycle start is accepted.
- busy  out  1  high from acceptance until DONE is entered.
- done  out  1  high in DONE; held until next accepted start.
- res_rd  out  1  result-RAM read strobe.
- res_addr  out  14  result-RAM read address, registered.
- res_di  in  8  result-RAM read data; valid the cycle after res_rd/res_addr.
- sti_wr  out  1  bitmap-RAM write strobe, registered.
- sti_addr  out  10  bitmap word address, registered.
- sti_do  out  16  bitmap word, registered.
- fg_count  out  15  number of pixels with res_di ≥ thr; final value valid with done.

## Operation
- States: IDLE, RUN, DRAIN, LAST, DONE.
- IDLE/DONE + start → RUN. On acceptance, the block:
  - latches thr into thr_q;
  - clears res_addr, fg_count, the shift register, the capture counter and done;
  - sets busy.
- RUN: res_rd=1 and res_addr increments by 1 each cycle, 0..16383. After the cycle with res_addr=16383, go to DRAIN; res_addr holds at 16383.
- DRAIN: res_rd=0. Captures the last pixel. Next state LAST.
- LAST: the final word write is on the bus. Next state DONE.
- DONE: done=1, busy=0. Stays until start.
- Capture:
  - A pixel is captured in every cycle following a cycle with res_rd=1.
  - bit = (res_di ≥ thr_q), unsigned compare.
  - The shift register shifts left with bit entering at the LSB, so pixel n of a word lands in bit 15−n.
  - fg_count increments when bit=1.
  - cap_cnt (14 b) increments per capture.
- Word emit: on capturing a pixel with cap_cnt[3:0]=15, register:
  - sti_do ← {shift[14:0], bit};
  - sti_addr ← cap_cnt[13:4];
  - sti_wr ← 1 for exactly one cycle.
- Otherwise sti_wr=0; sti_do and sti_addr hold their last values.
- start while busy is ignored; thr changes mid-run have no effect.
- Reset mid-operation forces all outputs to their reset values and the state to IDLE. Bitmap RAM is left partially written; no recovery is attempted.
- thr_q=0 → all bits 1 and fg_count=16384. thr_q=255 → only bytes equal to 255 set.
- fg_count maximum is 16384, so it needs 15 b and never wraps.

## Timing
- Reset values: busy 0, done 0, res_rd 0, res_addr 0, sti_wr 0, sti_addr 0, sti_do 0, fg_count 0.
- Cycle 0 = edge at which start is sampled.
- Cycles 1..16384: RUN, res_addr = cycle−1.
- Captures occur in cycles 2..16385.
- Word k: sti_wr high in cycle 16k+18, sti_addr=k. The first write is in cycle 18; the last (k=1023) is in cycle 16386 (LAST).
- done rises in cycle 16387, so start-to-done latency is 16387 cycles.
- Throughput: 1 pixel/cycle. Reads and writes overlap; the two RAMs are independent.
- sti_wr is never asserted on two consecutive cycles; the minimum spacing is 16 cycles.

## Structure
- Shared package dt_pkg:
  - IMG_W=128, PIX_NUM=16384, WORD_BITS=16, WORD_NUM=1024;
  - state enum;
  - res/sti address widths.
- The same package is used by the distance-transform engine.
- One sub-module, dt_bit_packer, holds:
  - the shift register and cap_cnt;
  - word-complete detection and the registered sti_wr/sti_addr/sti_do.
- The top level holds the FSM, read-address generator, threshold latch and fg_count.

## Test plan
- Res RAM all 0, thr=1 → 1024 writes of 0x0000; fg_count=0; done in cycle 16387.
- Res RAM all 0, thr=0 → every word 0xFFFF; fg_count=16384.
- res[0]=5, res[15]=5, res[16]=4, others 0, thr=5 → word0=0x8001, word1=0x0000; fg_count=2.
- Checkerboard: res[i]=(i odd)?200:0, thr=128 → every word 0x5555; fg_count=8192.
- Run DT output from a known bitmap, then pack with thr=1 → bitmap RAM equals the original sti image bit-for-bit.
- Two robustness checks:
  - Reset asserted in cycle 5000: all outputs return to reset values.
  - A later start completes normally; start pulses during RUN are ignored (busy stays high, addresses are uninterrupted).

Source files
------------

// File: rtl/dt_pkg.sv
// Shared constants and state type for the distance-transform datapath.
// Both the DT engine and the result packer import this package.
package dt_pkg;

    localparam int IMG_W     = 128;
    localparam int PIX_NUM   = IMG_W * IMG_W;
    localparam int WORD_BITS = 16;
    localparam int WORD_NUM  = PIX_NUM / WORD_BITS;
    localparam int RES_AW    = 14;
    localparam int STI_AW    = 10;
    localparam int FG_W      = 15;

    localparam logic [RES_AW-1:0] RES_LAST = RES_AW'(PIX_NUM - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_LAST,
        ST_DONE
    } dt_state_t;

endpackage

// File: rtl/dt_bit_packer.sv
// Packs the stream of thresholded pixel bits into 16-bit bitmap words.
// Pixel n of a word lands in bit 15-n; each full word is written exactly once.
module dt_bit_packer
    import dt_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 cap_en,
    input  logic                 pix_bit,
    output logic                 sti_wr,
    output logic [STI_AW-1:0]    sti_addr,
    output logic [WORD_BITS-1:0] sti_do
);

    logic [WORD_BITS-2:0] shift_q;
    logic [RES_AW-1:0]    cap_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q  <= '0;
            cap_cnt  <= '0;
            sti_wr   <= 1'b0;
            sti_addr <= '0;
            sti_do   <= '0;
        end else begin
            sti_wr <= 1'b0;
            if (clear) begin
                shift_q <= '0;
                cap_cnt <= '0;
            end else if (cap_en) begin
                shift_q <= {shift_q[WORD_BITS-3:0], pix_bit};
                cap_cnt <= cap_cnt + RES_AW'(1);
                // Sixteenth pixel of a word: emit it with the bit just captured.
                if (cap_cnt[3:0] == 4'hF) begin
                    sti_wr   <= 1'b1;
                    sti_do   <= {shift_q, pix_bit};
                    sti_addr <= cap_cnt[RES_AW-1:4];
                end
            end
        end
    end

endmodule

// File: rtl/dt_res_packer.sv
// Streams the 128x128 distance map out of the result RAM, thresholds each pixel
// and hands the bits to dt_bit_packer; also counts foreground pixels.
module dt_res_packer
    import dt_pkg::*;
#(
    parameter int THR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [THR_W-1:0]     thr,
    output logic                 busy,
    output logic                 done,
    output logic                 res_rd,
    output logic [RES_AW-1:0]    res_addr,
    input  logic [THR_W-1:0]     res_di,
    output logic                 sti_wr,
    output logic [STI_AW-1:0]    sti_addr,
    output logic [WORD_BITS-1:0] sti_do,
    output logic [FG_W-1:0]      fg_count
);

    dt_state_t        state_q, state_d;
    logic [THR_W-1:0] thr_q;
    logic             cap_en;
    logic             accept;
    logic             pix_bit;

    assign accept  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign pix_bit = (res_di >= thr_q);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
            ST_RUN:           if (res_addr == RES_LAST) state_d = ST_DRAIN;
            ST_DRAIN:         state_d = ST_LAST;
            ST_LAST:          state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            thr_q    <= '0;
            res_rd   <= 1'b0;
            res_addr <= '0;
            cap_en   <= 1'b0;
            fg_count <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q <= state_d;
            // Strobes are registered from the next state so they align with it.
            res_rd  <= (state_d == ST_RUN);
            busy    <= (state_d == ST_RUN) || (state_d == ST_DRAIN) || (state_d == ST_LAST);
            done    <= (state_d == ST_DONE);
            if (accept) begin
                thr_q    <= thr;
                res_addr <= '0;
                cap_en   <= 1'b0;
                fg_count <= '0;
            end else begin
                if (state_q == ST_RUN && res_addr != RES_LAST)
                    res_addr <= res_addr + RES_AW'(1);
                // Read data returns one cycle after the strobe.
                cap_en <= res_rd;
                if (cap_en && pix_bit)
                    fg_count <= fg_count + FG_W'(1);
            end
        end
    end

    dt_bit_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .cap_en   (cap_en),
        .pix_bit  (pix_bit),
        .sti_wr   (sti_wr),
        .sti_addr (sti_addr),
        .sti_do   (sti_do)
    );

endmodule

// File: tb/tb_dt_res_packer.sv
// Self-checking bench for dt_res_packer: table-driven full-image runs, a
// mid-run reset, and a randomized bitmap run checked against a pixel model.
module tb_dt_res_packer;
    import dt_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic [7:0]           thr = '0;
    logic                 busy, done, res_rd, sti_wr;
    logic [RES_AW-1:0]    res_addr;
    logic [7:0]           res_di = '0;
    logic [STI_AW-1:0]    sti_addr;
    logic [WORD_BITS-1:0] sti_do;
    logic [FG_W-1:0]      fg_count;

    logic [7:0]           mem     [PIX_NUM];
    logic [WORD_BITS-1:0] bmp     [WORD_NUM];
    logic [WORD_BITS-1:0] exp_bmp [WORD_NUM];

    int checks = 0;
    int failures = 0;

    typedef enum {P_ZERO, P_SPARSE, P_CHECK} pat_t;
    typedef struct {
        string      name;
        pat_t       pat;
        logic [7:0] thr;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] wn;
        int         fg;
    } vec_t;

    dt_res_packer #(.THR_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .thr      (thr),
        .busy     (busy),
        .done     (done),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_di   (res_di),
        .sti_wr   (sti_wr),
        .sti_addr (sti_addr),
        .sti_do   (sti_do),
        .fg_count (fg_count)
    );

    always #5 clk = ~clk;

    // Result RAM: data appears the cycle after the read strobe.
    always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, res_rd, res_addr, sti_wr, sti_addr, sti_do, fg_count});
    endfunction

    task automatic fill_mem(input pat_t p);
        for (int i = 0; i < PIX_NUM; i++) begin
            case (p)
                P_CHECK: mem[i] = (i % 2 == 1) ? 8'd200 : 8'd0;
                default: mem[i] = 8'd0;
            endcase
        end
        if (p == P_SPARSE) begin
            mem[0]  = 8'd5;
            mem[15] = 8'd5;
            mem[16] = 8'd4;
        end
    endtask

    task automatic run(input string name, input logic [7:0] t, input int exp_fg, input bit pulses);
        int done_at = -1;
        int nwr = 0;
        int seq_err = 0;
        int wr_err = 0;
        int wd_err = 0;
        for (int w = 0; w < WORD_NUM; w++) bmp[w] = 'x;
        @(negedge clk);
        start = 1'b1;
        thr = t;
        @(posedge clk);
        #1;
        start = 1'b0;
        thr = ~t;
        for (int c = 1; c <= 16500 && done_at < 0; c++) begin
            @(negedge clk);
            start = pulses && (c == 100 || c == 9000);
            if (pulses) thr = 8'($urandom);
            if (c <= PIX_NUM) begin
                if (!res_rd || res_addr != RES_AW'(c - 1) || !busy || done) seq_err++;
            end else if (c < PIX_NUM + 3) begin
                if (res_rd || res_addr != RES_LAST || !busy || done) seq_err++;
            end
            if (sti_wr) begin
                if (nwr >= WORD_NUM || c != 16 * nwr + 18 || sti_addr != STI_AW'(nwr)) wr_err++;
                bmp[sti_addr] = sti_do;
                nwr++;
            end
            if (done) done_at = c;
            @(posedge clk);
        end
        start = 1'b0;
        for (int w = 0; w < WORD_NUM; w++) if (bmp[w] !== exp_bmp[w]) wd_err++;
        check({name, ".latency"},  64'(done_at), 64'd16387);
        check({name, ".addr_seq"}, 64'(seq_err), 64'd0);
        check({name, ".wr_timing"},64'(wr_err),  64'd0);
        check({name, ".wr_count"}, 64'(nwr),     64'd1024);
        check({name, ".fg_count"}, 64'(fg_count), 64'(exp_fg));
        check({name, ".busy_low"}, 64'(busy),    64'd0);
        check({name, ".words"},    64'(wd_err),  64'd0);
    endtask

    vec_t vecs [4];

    initial begin
        int fg;
        logic [15:0] src;

        vecs[0] = '{"zero_thr1", P_ZERO,   8'd1,   16'h0000, 16'h0000, 16'h0000, 0};
        vecs[1] = '{"zero_thr0", P_ZERO,   8'd0,   16'hFFFF, 16'hFFFF, 16'hFFFF, 16384};
        vecs[2] = '{"sparse",    P_SPARSE, 8'd5,   16'h8001, 16'h0000, 16'h0000, 2};
        vecs[3] = '{"checker",   P_CHECK,  8'd128, 16'h5555, 16'h5555, 16'h5555, 8192};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_vals", all_outs(), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_quiet", all_outs(), 64'd0);

        for (int v = 0; v < 4; v++) begin
            fill_mem(vecs[v].pat);
            for (int w = 0; w < WORD_NUM; w++) exp_bmp[w] = vecs[v].wn;
            exp_bmp[0] = vecs[v].w0;
            exp_bmp[1] = vecs[v].w1;
            run(vecs[v].name, vecs[v].thr, vecs[v].fg, 1'b0);
        end

        // Abort a run with reset at cycle 5000.
        for (int i = 0; i < PIX_NUM; i++) mem[i] = 8'($urandom);
        @(negedge clk);
        start = 1'b1;
        thr = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4999) @(posedge clk);
        @(negedge clk);
        check("pre_abort_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_reset", all_outs(), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle", all_outs(), 64'd0);

        // Known bitmap expanded into a distance-like map, packed with thr=1.
        fg = 0;
        for (int w = 0; w < WORD_NUM; w++) begin
            src = 16'($urandom);
            for (int n = 0; n < 16; n++)
                mem[16 * w + n] = src[15 - n] ? 8'($urandom_range(1, 255)) : 8'd0;
        end
        for (int w = 0; w < WORD_NUM; w++) begin
            for (int n = 0; n < 16; n++) begin
                exp_bmp[w][15 - n] = (mem[16 * w + n] >= 8'd1);
                if (mem[16 * w + n] >= 8'd1) fg++;
            end
        end
        run("dt_bitmap", 8'd1, fg, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
